// File: rtl/timebase_counter.sv
// Programmable timebase: prescaler feeding an N-bit up/down counter with
// wrap, saturate and one-shot count modes plus run-time modulus.
module timebase_counter #(
    parameter int N     = 8,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [N-1:0]     load_val,
    input  logic [N-1:0]     max_val,
    input  logic [PRE_W-1:0] pre_div,
    output logic [N-1:0]     q,
    output logic             tick,
    output logic             done,
    output logic             running
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [PRE_W-1:0] pre_cnt;
    logic             sat;
    logic             active;
    logic             terminal;
    logic             arm;

    always_comb begin
        active = 1'b0;
        case (mode)
            2'd0, 2'd1: active = en;
            2'd2:       active = en && (state == RUN);
            default:    active = 1'b0;
        endcase
        tick    = active && (pre_cnt == pre_div);
        running = active;
        // Up-count uses >= so a max_val lowered below q still terminates.
        terminal = dir ? (q >= max_val) : (q == '0);
        arm      = (mode == 2'd2) && (state == IDLE) && start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            pre_cnt <= '0;
            done    <= 1'b0;
            sat     <= 1'b0;
            state   <= IDLE;
        end else if (clr) begin
            q       <= '0;
            pre_cnt <= '0;
            done    <= 1'b0;
            sat     <= 1'b0;
            state   <= IDLE;
        end else begin
            done <= 1'b0;

            if (mode != 2'd2)
                state <= IDLE;
            else if (arm)
                state <= RUN;
            else if ((state == RUN) && tick && terminal)
                state <= IDLE;

            if (load) begin
                q       <= load_val;
                pre_cnt <= '0;
                sat     <= 1'b0;
            end else begin
                if (arm || tick)
                    pre_cnt <= '0;
                else if (active)
                    pre_cnt <= pre_cnt + 1'b1;

                if (tick) begin
                    if (!terminal) begin
                        q   <= dir ? q + 1'b1 : q - 1'b1;
                        sat <= 1'b0;
                    end else begin
                        case (mode)
                            2'd0: begin
                                q    <= dir ? '0 : max_val;
                                done <= 1'b1;
                                sat  <= 1'b0;
                            end
                            // Saturate: report reaching the limit only once.
                            2'd1: begin
                                done <= !sat;
                                sat  <= 1'b1;
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_timebase_counter.sv
// Bench for timebase_counter: fixed vectors, directed corner sequences and
// randomized stimulus compared against an integer reference model.
module tb_timebase_counter;

    logic       clk, rst, clr, en, start, dir, load;
    logic [1:0] mode;
    logic [7:0] load_val, max_val, pre_div, q;
    logic       tick, done, running;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_q, m_pre, m_run, m_sat, m_done;
    int n_q, n_pre, n_run, n_sat, n_done;

    timebase_counter #(.N(8), .PRE_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .start(start),
        .mode(mode), .dir(dir), .load(load), .load_val(load_val),
        .max_val(max_val), .pre_div(pre_div), .q(q), .tick(tick),
        .done(done), .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr, en, load;
        logic [7:0] load_val;
        logic       start;
        logic [1:0] mode;
        logic       dir;
        logic [7:0] max_val, pre_div;
        int         eq, ed, et, er;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_active();
        case (mode)
            2'd0, 2'd1: return int'(en);
            2'd2:       return (en && m_run != 0) ? 1 : 0;
            default:    return 0;
        endcase
    endfunction

    function automatic int m_tick();
        return (m_active() != 0 && m_pre == int'(pre_div)) ? 1 : 0;
    endfunction

    function automatic int m_term();
        if (dir) return (m_q >= int'(max_val)) ? 1 : 0;
        return (m_q == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_q = 0; m_pre = 0; m_run = 0; m_sat = 0; m_done = 0;
    endtask

    task automatic model_next();
        int t, term, armed;
        t = m_tick(); term = m_term();
        armed = (mode == 2'd2 && m_run == 0 && start) ? 1 : 0;
        n_q = m_q; n_pre = m_pre; n_run = m_run; n_sat = m_sat; n_done = 0;
        if (clr) begin
            n_q = 0; n_pre = 0; n_run = 0; n_sat = 0;
            return;
        end
        if (mode != 2'd2) n_run = 0;
        else if (armed != 0) n_run = 1;
        else if (m_run != 0 && t != 0 && term != 0) n_run = 0;
        if (load) begin
            n_q = int'(load_val); n_pre = 0; n_sat = 0;
            return;
        end
        if (armed != 0 || t != 0) n_pre = 0;
        else if (m_active() != 0) n_pre = (m_pre + 1) % 256;
        if (t != 0) begin
            if (term == 0) begin
                n_q = dir ? (m_q + 1) % 256 : (m_q + 255) % 256;
                n_sat = 0;
            end else if (mode == 2'd0) begin
                n_q = dir ? 0 : int'(max_val);
                n_done = 1; n_sat = 0;
            end else if (mode == 2'd1) begin
                n_done = (m_sat == 0) ? 1 : 0;
                n_sat = 1;
            end else begin
                n_done = 1;
            end
        end
    endtask

    task automatic half_a();
        @(negedge clk);
        chk("model_q", int'(q), m_q);
        chk("model_done", int'(done), m_done);
        chk("model_tick", int'(tick), m_tick());
        chk("model_running", int'(running), m_active());
        model_next();
    endtask

    task automatic half_b();
        @(posedge clk);
        #1;
        m_q = n_q; m_pre = n_pre; m_run = n_run; m_sat = n_sat; m_done = n_done;
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_clr();
        clr = 1'b1; load = 1'b0; start = 1'b0;
        step();
        clr = 1'b0;
    endtask

    initial begin
        int dcount, n;

        vt[0]  = '{1,0,0,  0,0,0,1,3,0, 0,0,0,0};
        vt[1]  = '{0,1,0,  0,0,0,1,3,0, 0,0,1,1};
        vt[2]  = '{0,1,0,  0,0,0,1,3,0, 1,0,1,1};
        vt[3]  = '{0,1,0,  0,0,0,1,3,0, 2,0,1,1};
        vt[4]  = '{0,1,0,  0,0,0,1,3,0, 3,0,1,1};
        vt[5]  = '{0,1,0,  0,0,0,1,3,0, 0,1,1,1};
        vt[6]  = '{0,1,0,  0,0,0,1,3,0, 1,0,1,1};
        vt[7]  = '{0,1,1,200,0,0,1,3,0, 2,0,1,1};
        vt[8]  = '{0,1,0,  0,0,0,1,3,0, 200,0,1,1};
        vt[9]  = '{0,1,0,  0,0,0,1,3,0, 0,1,1,1};
        vt[10] = '{1,1,1, 50,0,0,1,3,0, 1,0,1,1};
        vt[11] = '{0,0,0,  0,0,0,1,3,0, 0,0,0,0};
        vt[12] = '{0,1,0,  0,0,3,1,3,0, 0,0,0,0};
        vt[13] = '{0,1,0,  0,0,2,1,3,0, 0,0,0,0};

        rst = 1'b1; clr = 1'b0; en = 1'b0; start = 1'b0; load = 1'b0;
        mode = 2'd0; dir = 1'b1; load_val = '0; max_val = 8'd3; pre_div = '0;
        model_reset();
        #7 rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            clr = vt[i].clr; en = vt[i].en; load = vt[i].load;
            load_val = vt[i].load_val; start = vt[i].start; mode = vt[i].mode;
            dir = vt[i].dir; max_val = vt[i].max_val; pre_div = vt[i].pre_div;
            half_a();
            chk($sformatf("vec%0d_q", i), int'(q), vt[i].eq);
            chk($sformatf("vec%0d_done", i), int'(done), vt[i].ed);
            chk($sformatf("vec%0d_tick", i), int'(tick), vt[i].et);
            chk($sformatf("vec%0d_running", i), int'(running), vt[i].er);
            half_b();
        end

        // prescaled down count with an enable gap
        do_clr();
        mode = 2'd0; dir = 1'b0; max_val = 8'd4; pre_div = 8'd3; en = 1'b1;
        load = 1'b1; load_val = 8'd4;
        step();
        load = 1'b0;
        steps(4);
        chk("pre_first_tick_q", int'(q), 3);
        steps(2);
        en = 1'b0;
        steps(3);
        chk("pre_frozen_q", int'(q), 3);
        en = 1'b1;
        step();
        chk("pre_resume_q", int'(q), 3);
        step();
        chk("pre_resume_tick_q", int'(q), 2);
        steps(8);
        chk("pre_at_zero_q", int'(q), 0);
        steps(3);
        chk("pre_before_wrap_done", int'(done), 0);
        step();
        chk("pre_wrap_q", int'(q), 4);
        chk("pre_wrap_done", int'(done), 1);

        // saturate up, then down
        do_clr();
        mode = 2'd1; dir = 1'b1; max_val = 8'd5; pre_div = 8'd0; en = 1'b1;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin step(); if (done) dcount++; end
        chk("sat_up_q", int'(q), 5);
        chk("sat_up_dones", dcount, 1);
        dir = 1'b0; dcount = 0;
        for (int i = 0; i < 10; i++) begin step(); if (done) dcount++; end
        chk("sat_down_q", int'(q), 0);
        chk("sat_down_dones", dcount, 1);

        // one-shot
        do_clr();
        mode = 2'd2; dir = 1'b1; max_val = 8'd3; pre_div = 8'd1; en = 1'b1;
        load = 1'b1; load_val = 8'd0; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        #1 chk("os_running", int'(running), 1);
        n = 0;
        while (n < 20) begin
            step(); n++;
            if (done) break;
        end
        chk("os_done_latency", n, 8);
        #1 chk("os_idle_running", int'(running), 0);
        chk("os_final_q", int'(q), 3);
        steps(4);
        chk("os_hold_q", int'(q), 3);
        start = 1'b1;
        step();
        start = 1'b0;
        #1 chk("os_rearm_running", int'(running), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("os_start_in_run_done", int'(done), 0);
        step();
        chk("os_rearm_done", int'(done), 1);
        #1 chk("os_rearm_idle", int'(running), 0);

        // lowering max_val below q
        do_clr();
        mode = 2'd0; dir = 1'b1; max_val = 8'd20; pre_div = 8'd0; en = 1'b1;
        load = 1'b1; load_val = 8'd7;
        step();
        load = 1'b0; max_val = 8'd5;
        step();
        chk("lowmax_q", int'(q), 0);
        chk("lowmax_done", int'(done), 1);

        // asynchronous reset mid-run
        do_clr();
        mode = 2'd2; dir = 1'b1; max_val = 8'd200; pre_div = 8'd0; en = 1'b1;
        load = 1'b1; load_val = 8'd0; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        steps(3);
        #2 rst = 1'b1;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_running", int'(running), 0);
        chk("arst_tick", int'(tick), 0);
        model_reset();
        #1 rst = 1'b0;
        step();

        // randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            clr   = ($urandom % 60) == 0;
            load  = ($urandom % 25) == 0;
            start = ($urandom % 8) == 0;
            en    = ($urandom % 10) != 0;
            load_val = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            if (($urandom % 40) == 0) mode = 2'($urandom);
            if (($urandom % 30) == 0) dir = 1'($urandom);
            if (($urandom % 50) == 0)
                max_val = (($urandom % 6) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
            if (($urandom % 50) == 0) pre_div = 8'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
